// File: rtl/fir_pkg.sv
// Shared types and defaults for the FIR output-side blocks.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } fir_state_e;

    localparam int FIR_DW    = 12;
    localparam int FIR_ORDER = 8;
    localparam int FIR_CNT_W = 16;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int unsigned value);
        int r;
        r = 0;
        for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_out_fifo.sv
// First-word-fall-through FIFO: head entry is visible whenever the FIFO is non-empty.
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int  DW    = FIR_DW,
    parameter int  DEPTH = 8,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_req,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_req,
    output logic          wr_ok,
    output logic [DW-1:0] rd_data,
    output logic          valid,
    output logic [AW:0]   level
);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          empty, full, rd_ok;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        level = wr_ptr_q - rd_ptr_q;
        valid = !empty;
        rd_ok = rd_req && !empty;
        // A read on the same edge frees a slot, so a full FIFO still takes the write.
        wr_ok = wr_req && (!full || rd_ok);
        rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fir_out_buffer.sv
// Output buffer for the FIR filter: FWFT FIFO with valid/ready drain, sample
// counting, drop flag and end-of-stream detection.
module fir_out_buffer
    import fir_pkg::*;
#(
    parameter int DW           = FIR_DW,
    parameter int DEPTH        = 8,
    parameter int IDLE_TIMEOUT = 16,
    parameter int CNT_W        = FIR_CNT_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DW-1:0]        DIN,
    input  logic                 VIN,
    output logic [DW-1:0]        DOUT,
    output logic                 VOUT,
    input  logic                 READY_I,
    output logic [clog2(DEPTH):0] LEVEL,
    output logic [CNT_W-1:0]     COUNT,
    output logic                 OVF,
    output logic                 END_SIM
);

    localparam int ICW = clog2(IDLE_TIMEOUT + 1);
    localparam logic [ICW-1:0] IDLE_MAX = ICW'(IDLE_TIMEOUT);

    fir_state_e       state_q, state_d;
    logic [ICW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             wr_req, wr_ok;

    fir_out_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .wr_req  (wr_req),
        .wr_data (DIN),
        .rd_req  (READY_I),
        .wr_ok   (wr_ok),
        .rd_data (DOUT),
        .valid   (VOUT),
        .level   (LEVEL)
    );

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        wr_req     = 1'b0;
        case (state_q)
            IDLE: begin
                if (VIN) begin
                    wr_req  = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                wr_req = VIN;
                if (VIN) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q != IDLE_MAX) begin
                    idle_cnt_d = idle_cnt_q + ICW'(1);
                end
                if (idle_cnt_d == IDLE_MAX) state_d = DRAIN;
            end
            DRAIN: begin
                if (VIN) begin
                    wr_req     = 1'b1;
                    idle_cnt_d = '0;
                    state_d    = STREAM;
                end else if (LEVEL == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    ;
            default: state_d = IDLE;
        endcase

        // Samples arriving after end of stream are treated as drops.
        ovf_d = ovf_q | (wr_req && !wr_ok) | ((state_q == DONE) && VIN);

        count_d = count_q;
        if (wr_ok && (count_q != '1)) count_d = count_q + CNT_W'(1);

        COUNT   = count_q;
        OVF     = ovf_q;
        END_SIM = (state_q == DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            idle_cnt_q <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fir_out_buffer.sv
// Directed bench for fir_out_buffer: FWFT latency, overflow, full-with-read,
// end-of-stream drain, re-entry to STREAM and mid-stream reset.
module tb_fir_out_buffer;
    import fir_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] din;
    logic        vin;
    logic        ready_i;
    logic [11:0] dout;
    logic        vout;
    logic [3:0]  level;
    logic [15:0] count;
    logic        ovf;
    logic        end_sim;

    int n_tests = 0;
    int n_fail  = 0;

    fir_out_buffer #(
        .DW           (12),
        .DEPTH        (8),
        .IDLE_TIMEOUT (16),
        .CNT_W        (16)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .DIN     (din),
        .VIN     (vin),
        .DOUT    (dout),
        .VOUT    (vout),
        .READY_I (ready_i),
        .LEVEL   (level),
        .COUNT   (count),
        .OVF     (ovf),
        .END_SIM (end_sim)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] s12(input int v);
        logic [11:0] t;
        t = v[11:0];
        return {20'd0, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; vin = 1'b0; ready_i = 1'b0; din = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input int v);
        din = v[11:0];
        vin = 1'b1;
        tick();
    endtask

    function automatic logic [31:0] st();
        return 32'(dut.state_q);
    endfunction

    initial begin
        int vals[4];
        vals = '{5, -3, 2047, -2048};

        // Reset state
        do_reset();
        check_eq("rst_dout",    32'(dout),    32'd0);
        check_eq("rst_vout",    32'(vout),    32'd0);
        check_eq("rst_level",   32'(level),   32'd0);
        check_eq("rst_count",   32'(count),   32'd0);
        check_eq("rst_ovf",     32'(ovf),     32'd0);
        check_eq("rst_end_sim", 32'(end_sim), 32'd0);
        check_eq("rst_state",   st(),         32'(IDLE));

        // Extreme signed values pass bit-exact, one cycle after write
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(vals[i]);
            check_eq($sformatf("pass_vout_%0d", i), 32'(vout), 32'd1);
            check_eq($sformatf("pass_dout_%0d", i), 32'(dout), s12(vals[i]));
            vin = 1'b0;
            tick();
            check_eq($sformatf("pass_empty_%0d", i), 32'(vout), 32'd0);
        end
        check_eq("pass_count", 32'(count), 32'd4);
        check_eq("pass_ovf",   32'(ovf),   32'd0);

        // Overflow: 10 writes into 8 entries with no reader
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            push(i);
            check_eq($sformatf("ovf_level_%0d", i), 32'(level), (i > 8) ? 32'd8 : 32'(i));
            check_eq($sformatf("ovf_flag_%0d", i),  32'(ovf),   (i > 8) ? 32'd1 : 32'd0);
        end
        vin = 1'b0;
        check_eq("ovf_count", 32'(count), 32'd8);
        ready_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check_eq($sformatf("ovf_drain_%0d", k), 32'(dout), s12(k));
            tick();
        end
        check_eq("ovf_drained", 32'(vout), 32'd0);

        // Full FIFO, read and write on the same edge
        do_reset();
        for (int i = 1; i <= 8; i++) push(i);
        check_eq("full_level", 32'(level), 32'd8);
        ready_i = 1'b1;
        push(100);
        vin = 1'b0;
        check_eq("full_rw_level", 32'(level), 32'd8);
        check_eq("full_rw_ovf",   32'(ovf),   32'd0);
        check_eq("full_rw_count", 32'(count), 32'd9);
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("full_rw_seq_%0d", k), 32'(dout), (k < 7) ? s12(k + 2) : s12(100));
            tick();
        end
        check_eq("full_rw_empty", 32'(vout), 32'd0);

        // Idle timeout -> DRAIN -> DONE
        do_reset();
        push(11); push(12); push(13);
        vin = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check_eq("eos_state_15", st(), 32'(STREAM));
        tick();
        check_eq("eos_state_16", st(), 32'(DRAIN));
        check_eq("eos_level",    32'(level), 32'd3);
        ready_i = 1'b1;
        tick(); tick(); tick();
        check_eq("eos_level0",   32'(level),   32'd0);
        check_eq("eos_end_pre",  32'(end_sim), 32'd0);
        tick();
        check_eq("eos_end_sim",  32'(end_sim), 32'd1);
        push(99);
        vin = 1'b0;
        check_eq("eos_late_ovf",   32'(ovf),   32'd1);
        check_eq("eos_late_count", 32'(count), 32'd3);
        check_eq("eos_late_vout",  32'(vout),  32'd0);
        tick();
        check_eq("eos_end_hold",   32'(end_sim), 32'd1);

        // New sample while draining returns to STREAM
        do_reset();
        push(21); push(22);
        vin = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        check_eq("redo_drain",  st(), 32'(DRAIN));
        check_eq("redo_level2", 32'(level), 32'd2);
        push(7);
        vin = 1'b0;
        check_eq("redo_state",  st(), 32'(STREAM));
        check_eq("redo_level3", 32'(level), 32'd3);
        ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("redo_seq_%0d", k), 32'(dout), (k == 0) ? s12(21) : (k == 1) ? s12(22) : s12(7));
            tick();
        end
        check_eq("redo_end_sim", 32'(end_sim), 32'd0);

        // Mid-stream reset discards buffered data
        do_reset();
        for (int i = 31; i <= 35; i++) push(i);
        vin = 1'b0;
        check_eq("mrst_level5", 32'(level), 32'd5);
        rst = 1'b1;
        #1;
        check_eq("mrst_pre_edge", 32'(level), 32'd5);
        tick();
        rst = 1'b0;
        check_eq("mrst_vout",  32'(vout),  32'd0);
        check_eq("mrst_level", 32'(level), 32'd0);
        check_eq("mrst_count", 32'(count), 32'd0);
        check_eq("mrst_dout",  32'(dout),  32'd0);
        check_eq("mrst_state", st(),       32'(IDLE));
        push(40);
        vin = 1'b0;
        check_eq("mrst_new_vout",  32'(vout),  32'd1);
        check_eq("mrst_new_dout",  32'(dout),  s12(40));
        check_eq("mrst_new_count", 32'(count), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
